// File: rtl/regfile_sequencer_if.sv
// Signal bundle between the lab front-end, the register-file sequencer and the 8x4 register file.
// The sequencer takes the slave view; the front-end/register-file side takes the master view.
interface regfile_sequencer_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
);
  logic              instr_valid;
  logic              instr_ready;
  logic [1:0]        opcode;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] srca;
  logic [ADDR_W-1:0] srcb;
  logic [DATA_W-1:0] imm;
  logic [ADDR_W-1:0] rp;
  logic [ADDR_W-1:0] rq;
  logic [DATA_W-1:0] datap;
  logic [DATA_W-1:0] dataq;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] ld_data;
  logic              wr;
  logic [DATA_W-1:0] result;
  logic              carry;
  logic              done;

  modport slave (
    input  instr_valid, opcode, dst, srca, srcb, imm, datap, dataq,
    output instr_ready, rp, rq, wa, ld_data, wr, result, carry, done
  );

  modport master (
    output instr_valid, opcode, dst, srca, srcb, imm, datap, dataq,
    input  instr_ready, rp, rq, wa, ld_data, wr, result, carry, done
  );
endinterface

// File: rtl/regfile_sequencer.sv
// Single-issue instruction sequencer for an 8x4 register file: read operands, execute
// LDI/MOV/ADD/SUB, then issue a one-cycle write strobe.
module regfile_sequencer #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
) (
  input logic              clk,
  input logic              rst_n,
  regfile_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_MOV = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  state_t            state_reg, state_next;
  logic [1:0]        opcode_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [DATA_W-1:0] imm_reg;
  logic [DATA_W-1:0] opa_reg, opb_reg;
  logic [ADDR_W-1:0] rp_reg, rq_reg, wa_reg;
  logic [DATA_W-1:0] ld_data_reg, result_reg;
  logic              carry_reg;

  logic              accept;
  logic              ready_next, wr_next;
  logic [DATA_W:0]   alu_sum, alu_diff;

  assign accept = bus.instr_valid && (state_reg == IDLE);

  always_comb begin
    state_next = state_reg;
    ready_next = 1'b0;
    wr_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_next = 1'b1;
        if (bus.instr_valid)
          state_next = (bus.opcode == OP_LDI) ? EXEC : READ;
      end
      READ:  state_next = EXEC;
      EXEC:  state_next = WRITE;
      WRITE: begin
        wr_next    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Subtraction as opA + ~opB + 1, so the top bit is "no borrow".
  always_comb begin
    alu_sum  = {1'b0, opa_reg} + {1'b0, opb_reg};
    alu_diff = {1'b0, opa_reg} + {1'b0, ~opb_reg} + (DATA_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      opcode_reg  <= '0;
      dst_reg     <= '0;
      imm_reg     <= '0;
      opa_reg     <= '0;
      opb_reg     <= '0;
      rp_reg      <= '0;
      rq_reg      <= '0;
      wa_reg      <= '0;
      ld_data_reg <= '0;
      result_reg  <= '0;
      carry_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        opcode_reg <= bus.opcode;
        dst_reg    <= bus.dst;
        imm_reg    <= bus.imm;
        // Read selects load at acceptance so they are valid throughout READ and hold after.
        if (bus.opcode != OP_LDI) begin
          rp_reg <= bus.srca;
          rq_reg <= bus.srcb;
        end
      end
      if (state_reg == READ) begin
        opa_reg <= bus.datap;
        opb_reg <= bus.dataq;
      end
      if (state_reg == EXEC) begin
        wa_reg <= dst_reg;
        case (opcode_reg)
          OP_LDI: begin
            result_reg  <= imm_reg;
            ld_data_reg <= imm_reg;
          end
          OP_MOV: begin
            result_reg  <= opa_reg;
            ld_data_reg <= opa_reg;
          end
          OP_ADD: begin
            {carry_reg, result_reg} <= alu_sum;
            ld_data_reg             <= alu_sum[DATA_W-1:0];
          end
          default: begin
            {carry_reg, result_reg} <= alu_diff;
            ld_data_reg             <= alu_diff[DATA_W-1:0];
          end
        endcase
      end
    end
  end

  // Strobes decode straight from state so an async reset removes them immediately.
  assign bus.instr_ready = ready_next;
  assign bus.wr          = wr_next;
  assign bus.done        = wr_next;
  assign bus.rp          = rp_reg;
  assign bus.rq          = rq_reg;
  assign bus.wa          = wa_reg;
  assign bus.ld_data     = ld_data_reg;
  assign bus.result      = result_reg;
  assign bus.carry       = carry_reg;

endmodule
